// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: operands flow master->slave,
// result flows slave->master, each side with its own valid/ready pair.
interface seq_alu_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [CTRL_WIDTH-1:0] ALU_Ctrl;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] R;
  logic [DATA_WIDTH-1:0] S;
  logic                  ALU_Exception;

  modport master (
    output in_valid, A, B, ALU_Ctrl, out_ready,
    input  in_ready, out_valid, R, S, ALU_Exception
  );

  modport slave (
    input  in_valid, A, B, ALU_Ctrl, out_ready,
    output in_ready, out_valid, R, S, ALU_Exception
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift/rotate, iterative
// shift-add MUL and restoring DIV (one bit per cycle), result as {S,R}.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand handshake
// ITER  | MUL/DIV stepping one bit per cycle, counter 0..W-1
// DONE  | out_valid=1, result held until out_ready
module seq_alu #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 4
) (
  input logic    clk,
  input logic    rst_n,
  seq_alu_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CB = $clog2(W);
  localparam logic [CB-1:0] LAST = CB'(W - 1);
  localparam logic [W-1:0]  W_L  = W'(W);
  localparam logic [W-1:0]  W2_L = W'(2 * W);

  localparam logic [CTRL_WIDTH-1:0] OP_NOP = CTRL_WIDTH'(4'b0000);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL = CTRL_WIDTH'(4'b0001);
  localparam logic [CTRL_WIDTH-1:0] OP_DIV = CTRL_WIDTH'(4'b0010);
  localparam logic [CTRL_WIDTH-1:0] OP_ROR = CTRL_WIDTH'(4'b1000);
  localparam logic [CTRL_WIDTH-1:0] OP_ROL = CTRL_WIDTH'(4'b1001);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL = CTRL_WIDTH'(4'b1010);
  localparam logic [CTRL_WIDTH-1:0] OP_SLR = CTRL_WIDTH'(4'b1011);
  localparam logic [CTRL_WIDTH-1:0] OP_OR  = CTRL_WIDTH'(4'b1100);
  localparam logic [CTRL_WIDTH-1:0] OP_AND = CTRL_WIDTH'(4'b1101);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB = CTRL_WIDTH'(4'b1110);
  localparam logic [CTRL_WIDTH-1:0] OP_ADD = CTRL_WIDTH'(4'b1111);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    r_q;
  logic [W-1:0]    s_q;
  logic            exc_q;
  logic [CB-1:0]   cnt_q;
  logic            mul_q;
  logic [W-1:0]    acc_q;   // MUL: product high half; DIV: partial remainder
  logic [W-1:0]    lo_q;    // MUL: multiplier/product low; DIV: dividend/quotient
  logic [W-1:0]    opnd_q;  // MUL: multiplicand A; DIV: divisor B

  // Single-cycle results and the accept decision, from the live operands.
  logic [W:0]      add_w;
  logic [W:0]      sub_w;
  logic [2*W-1:0]  sll_w;
  logic [CB-1:0]   rot_amt;
  logic [W-1:0]    r_d;
  logic [W-1:0]    s_d;
  logic            exc_d;
  logic            iter_d;

  always_comb begin
    add_w   = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w   = {1'b0, bus.A} - {1'b0, bus.B};
    sll_w   = {{W{1'b0}}, bus.A} << bus.B;
    rot_amt = bus.B[CB-1:0];
    r_d     = '0;
    s_d     = '0;
    exc_d   = 1'b0;
    iter_d  = 1'b0;
    case (bus.ALU_Ctrl)
      OP_ADD: begin
        r_d    = add_w[W-1:0];
        s_d[0] = add_w[W];
        exc_d  = (bus.A[W-1] == bus.B[W-1]) && (add_w[W-1] != bus.A[W-1]);
      end
      OP_SUB: begin
        r_d    = sub_w[W-1:0];
        s_d[0] = sub_w[W];
        exc_d  = (bus.A[W-1] != bus.B[W-1]) && (sub_w[W-1] != bus.A[W-1]);
      end
      OP_AND: r_d = bus.A & bus.B;
      OP_OR:  r_d = bus.A | bus.B;
      OP_MUL: iter_d = 1'b1;
      OP_DIV: begin
        if (bus.B == '0) begin
          r_d   = '1;
          s_d   = bus.A;
          exc_d = 1'b1;
        end else begin
          iter_d = 1'b1;
        end
      end
      OP_SLL: begin
        if (bus.B < W2_L) {s_d, r_d} = sll_w;
      end
      OP_SLR: begin
        if (bus.B < W_L) r_d = bus.A >> bus.B;
      end
      OP_ROL: r_d = W'(({bus.A, bus.A} << rot_amt) >> W);
      OP_ROR: r_d = W'({bus.A, bus.A} >> rot_amt);
      OP_NOP: r_d = '0;
      default: exc_d = 1'b1;
    endcase
  end

  // One iteration step for each of the two multi-cycle operations.
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_nxt;
  logic [W:0]      div_trial;
  logic [W:0]      div_diff;
  logic [W-1:0]    rem_nxt;
  logic [W-1:0]    quo_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
    mul_nxt   = lo_q[0] ? {mul_sum, lo_q[W-1:1]} : {1'b0, acc_q, lo_q[W-1:1]};
    div_trial = {acc_q, lo_q[W-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    // A negative trial never has its top bit set, so the low W bits suffice.
    rem_nxt   = div_diff[W] ? div_trial[W-1:0] : div_diff[W-1:0];
    quo_nxt   = {lo_q[W-2:0], ~div_diff[W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      s_q         <= '0;
      exc_q       <= 1'b0;
      cnt_q       <= '0;
      mul_q       <= 1'b0;
      acc_q       <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mul_q      <= (bus.ALU_Ctrl == OP_MUL);
            if (iter_d) begin
              state_q <= ITER;
              lo_q    <= (bus.ALU_Ctrl == OP_MUL) ? bus.B : bus.A;
              opnd_q  <= (bus.ALU_Ctrl == OP_MUL) ? bus.A : bus.B;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              r_q         <= r_d;
              s_q         <= s_d;
              exc_q       <= exc_d;
            end
          end
        end
        ITER: begin
          if (mul_q) begin
            {acc_q, lo_q} <= mul_nxt;
          end else begin
            acc_q <= rem_nxt;
            lo_q  <= quo_nxt;
          end
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            exc_q       <= 1'b0;
            r_q         <= mul_q ? mul_nxt[W-1:0] : quo_nxt;
            s_q         <= mul_q ? mul_nxt[2*W-1:W] : rem_nxt;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.R             = r_q;
  assign bus.S             = s_q;
  assign bus.ALU_Exception = exc_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (W=16): directed corner cases plus random ops against an
// arithmetic reference model of the function table and latencies.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.DATA_WIDTH(16), .CTRL_WIDTH(4)) bus ();

  seq_alu #(.DATA_WIDTH(16), .CTRL_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: result, exception and accept->out_valid latency.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, b,
                                output logic [15:0] r, s, output logic e, output int lat);
    longint p;
    int sa, sb, k;
    r = 16'h0; s = 16'h0; e = 1'b0; lat = 1;
    sa = $signed(a); sb = $signed(b);
    k = int'(b) % 16;
    case (op)
      4'hF: begin
        p = longint'(a) + longint'(b);
        r = p[15:0]; s = {15'b0, p[16]};
        e = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'hE: begin
        r = 16'(a - b); s = (a < b) ? 16'h1 : 16'h0;
        e = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'hD: r = a & b;
      4'hC: r = a | b;
      4'h1: begin
        p = longint'(a) * longint'(b);
        r = p[15:0]; s = p[31:16]; lat = 17;
      end
      4'h2: begin
        if (b == 16'h0) begin
          r = 16'hFFFF; s = a; e = 1'b1;
        end else begin
          r = a / b; s = a % b; lat = 17;
        end
      end
      4'hA: if (b < 32) begin
        p = longint'(a) << b;
        r = p[15:0]; s = p[31:16];
      end
      4'hB: if (b < 16) r = a >> b;
      4'h9: r = (k == 0) ? a : 16'((int'(a) << k) | (int'(a) >> (16 - k)));
      4'h8: r = (k == 0) ? a : 16'((int'(a) >> k) | (int'(a) << (16 - k)));
      4'h0: r = 16'h0;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, b,
                        input int hold, input bit noise, input string name);
    logic [15:0] er, es;
    logic ee;
    int elat, lat, guard;
    model(op, a, b, er, es, ee, elat);
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin step(); guard++; end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready_before got=%b want=1", name, bus.in_ready);
    end
    bus.A = a; bus.B = b; bus.ALU_Ctrl = op; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_valid = noise;
    if (noise) begin
      bus.A = 16'($urandom); bus.B = 16'($urandom); bus.ALU_Ctrl = 4'($urandom);
    end
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin step(); lat++; end
    total++;
    if (lat != elat) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, elat);
    end
    total++;
    if (bus.R !== er) begin
      bad++; $display("FAIL %s R got=%h want=%h (op=%b A=%h B=%h)", name, bus.R, er, op, a, b);
    end
    total++;
    if (bus.S !== es) begin
      bad++; $display("FAIL %s S got=%h want=%h (op=%b A=%h B=%h)", name, bus.S, es, op, a, b);
    end
    total++;
    if (bus.ALU_Exception !== ee) begin
      bad++; $display("FAIL %s Exc got=%b want=%b (op=%b A=%h B=%h)", name, bus.ALU_Exception, ee, op, a, b);
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL %s in_ready_busy got=%b want=0", name, bus.in_ready);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      total++;
      if ({bus.out_valid, bus.in_ready, bus.R, bus.S, bus.ALU_Exception} !== {1'b1, 1'b0, er, es, ee}) begin
        bad++;
        $display("FAIL %s hold_cycle%0d got v=%b rdy=%b R=%h S=%h E=%b want v=1 rdy=0 R=%h S=%h E=%b",
                 name, i, bus.out_valid, bus.in_ready, bus.R, bus.S, bus.ALU_Exception, er, es, ee);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++; $display("FAIL %s drain got v=%b rdy=%b want v=0 rdy=1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++;
    if ({bus.in_ready, bus.out_valid, bus.R, bus.S, bus.ALU_Exception} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      bad++; $display("FAIL reset got rdy=%b v=%b R=%h S=%h E=%b want rdy=1 v=0 R=0 S=0 E=0",
                      bus.in_ready, bus.out_valid, bus.R, bus.S, bus.ALU_Exception);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_op(4'hF, 16'h7FFF, 16'h0001, 0, 0, "add_ovf");
    run_op(4'hF, 16'hFFFF, 16'h0001, 0, 0, "add_carry");
    run_op(4'hE, 16'h8000, 16'h0001, 0, 0, "sub_ovf");
    run_op(4'hE, 16'h0001, 16'h0002, 0, 0, "sub_borrow");
    run_op(4'h1, 16'hFFFF, 16'hFFFF, 0, 0, "mul_max");
    run_op(4'h2, 16'h0064, 16'h0007, 0, 0, "div_100_7");
    run_op(4'h2, 16'h1234, 16'h0000, 0, 0, "div_zero");
    run_op(4'h9, 16'h8001, 16'h0011, 0, 0, "rol");
    run_op(4'h8, 16'h0001, 16'h0001, 0, 0, "ror");
    run_op(4'hA, 16'h8001, 16'h0001, 0, 0, "sll_1");
    run_op(4'hA, 16'h8001, 16'h001F, 0, 0, "sll_31");
    run_op(4'hA, 16'h8001, 16'h0020, 0, 0, "sll_32");
    run_op(4'hB, 16'h8001, 16'h0010, 0, 0, "slr_16");
    run_op(4'h0, 16'h1234, 16'h5678, 0, 0, "nop");
    run_op(4'h3, 16'h1234, 16'h5678, 0, 0, "undef_0011");
  endtask

  task automatic test_hold();
    run_op(4'h2, 16'h0064, 16'h0007, 10, 1, "div_hold");
    run_op(4'hD, 16'hF0F0, 16'h3C3C, 10, 1, "and_hold");
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    run_op(4'hC, 16'hA5A5, 16'h0F0F, 0, 0, "pre_or");
    bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.ALU_Ctrl = 4'h1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.R, bus.S} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
      bad++; $display("FAIL reset_mid_mul got rdy=%b v=%b R=%h S=%h want rdy=1 v=0 R=0 S=0",
                      bus.in_ready, bus.out_valid, bus.R, bus.S);
    end
    seen = 1'b0;
    repeat (30) begin
      step();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL reset_mid_mul_no_result got out_valid_seen=%b want=0", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [15:0] a, b;
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      if (op == 4'h2 && $urandom_range(0, 7) == 0) b = 16'h0;
      run_op(op, a, b, $urandom_range(0, 2), 1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++)
      run_op(4'(n % 2 ? 4'h1 : 4'hF), 16'($urandom), 16'($urandom), 0, 0, "b2b");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = 16'h0; bus.B = 16'h0; bus.ALU_Ctrl = 4'h0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
